// File: rtl/cam_pkg.sv
// Shared definitions for the parallel camera capture path: geometry defaults,
// FSM encoding and the RGB565 -> RGB332 reduction.
package cam_pkg;

    localparam int unsigned IMG_W_DEF = 160;
    localparam int unsigned IMG_H_DEF = 120;
    localparam int unsigned AW_DEF    = 15;
    localparam int unsigned PX_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } cam_state_e;

    // Keep the top bits of each colour channel: {R[2:0], G[2:0], B[1:0]}.
    function automatic logic [7:0] rgb565_to_332(input logic [15:0] px);
        return {px[15:13], px[10:8], px[4:3]};
    endfunction

endpackage

// File: rtl/cam_sync.sv
// Two-flop synchronizer bank for the camera pins plus a registered
// rising-edge strobe on pclk, with data delayed to stay aligned to the strobe.
module cam_sync #(
    parameter int unsigned W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pclk_i,
    input  logic [W-1:0] data_i,
    output logic         pstb_o,
    output logic [W-1:0] data_o
);

    logic [1:0]   pclk_sync_q;
    logic         pclk_dly_q;
    logic         pstb_q;
    logic [W-1:0] data_s1_q;
    logic [W-1:0] data_s2_q;
    logic [W-1:0] data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pclk_sync_q <= '0;
            pclk_dly_q  <= 1'b0;
            pstb_q      <= 1'b0;
            data_s1_q   <= '0;
            data_s2_q   <= '0;
            data_q      <= '0;
        end else begin
            pclk_sync_q <= {pclk_sync_q[0], pclk_i};
            data_s1_q   <= data_i;
            data_s2_q   <= data_s1_q;
            pclk_dly_q  <= pclk_sync_q[1];
            pstb_q      <= pclk_sync_q[1] & ~pclk_dly_q;
            data_q      <= data_s2_q;
        end
    end

    assign pstb_o = pstb_q;
    assign data_o = data_q;

endmodule

// File: rtl/cam_capture.sv
// OV7670-style camera receiver: pairs RGB565 bytes, reduces them to RGB332
// and writes them to the frame buffer at a running linear address.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    input  logic            CAM_pclk,
    input  logic            CAM_vsync,
    input  logic            CAM_href,
    input  logic [PX_W-1:0] CAM_px_data,
    output logic [AW-1:0]   mem_addr,
    output logic [7:0]      mem_data,
    output logic            mem_we,
    output logic            frame_done,
    output logic            line_err
);

    localparam int unsigned CW = $clog2(IMG_W + 1);
    localparam int unsigned RW = $clog2(IMG_H + 1);
    localparam int unsigned SW = PX_W + 2;
    localparam logic [CW-1:0] COL_END   = CW'(IMG_W);
    localparam logic [RW-1:0] ROW_END   = RW'(IMG_H);
    localparam logic [AW-1:0] LINE_STEP = AW'(IMG_W);

    logic            pstb;
    logic [SW-1:0]   sync_data;
    logic            vsync_s;
    logic            href_s;
    logic [PX_W-1:0] byte_s;

    cam_sync #(.W(SW)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .pclk_i (CAM_pclk),
        .data_i ({CAM_vsync, CAM_href, CAM_px_data}),
        .pstb_o (pstb),
        .data_o (sync_data)
    );

    assign vsync_s = sync_data[SW-1];
    assign href_s  = sync_data[SW-2];
    assign byte_s  = sync_data[PX_W-1:0];

    cam_state_e      state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic            phase_q, phase_d;
    logic [PX_W-1:0] hi_q, hi_d;
    logic            href_prev_q, href_prev_d;
    logic            line_px_q, line_px_d;
    logic [AW-1:0]   base_q, base_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]      mem_data_q, mem_data_d;
    logic            mem_we_q, mem_we_d;
    logic            frame_done_q, frame_done_d;
    logic            line_err_q, line_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Enable is only looked at when deciding whether to arm for the next frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (pstb && enable && vsync_s) state_d = ST_WAIT_VS;
            ST_WAIT_VS: if (pstb && !vsync_s)          state_d = ST_CAPTURE;
            ST_CAPTURE: if (pstb && vsync_s)           state_d = enable ? ST_WAIT_VS : ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        row_d        = row_q;
        col_d        = col_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        href_prev_d  = href_prev_q;
        line_px_d    = line_px_q;
        base_d       = base_q;
        addr_d       = addr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        line_err_d   = line_err_q;

        if (pstb) href_prev_d = href_s;

        case (state_q)
            ST_WAIT_VS: begin
                if (pstb && !vsync_s) begin
                    row_d      = '0;
                    col_d      = '0;
                    phase_d    = 1'b0;
                    line_err_d = 1'b0;
                    line_px_d  = 1'b0;
                    base_d     = '0;
                    addr_d     = '0;
                end
            end
            ST_CAPTURE: begin
                if (pstb) begin
                    if (vsync_s) begin
                        frame_done_d = 1'b1;
                    end else if (href_s) begin
                        if (!phase_q) begin
                            hi_d    = byte_s;
                            phase_d = 1'b1;
                        end else begin
                            mem_data_d = rgb565_to_332({hi_q, byte_s});
                            if (col_q < COL_END && row_q < ROW_END) begin
                                mem_we_d   = 1'b1;
                                mem_addr_d = addr_q;
                                addr_d     = addr_q + AW'(1);
                            end
                            if (col_q < COL_END) col_d = col_q + CW'(1);
                            phase_d   = 1'b0;
                            line_px_d = 1'b1;
                        end
                    end else if (href_prev_q) begin
                        // Line end: short lines still advance the address to the next row base.
                        if (phase_q) line_err_d = 1'b1;
                        col_d     = '0;
                        phase_d   = 1'b0;
                        line_px_d = 1'b0;
                        if (line_px_q && row_q < ROW_END) begin
                            row_d  = row_q + RW'(1);
                            base_d = base_q + LINE_STEP;
                            addr_d = base_q + LINE_STEP;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= '0;
            col_q        <= '0;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            href_prev_q  <= 1'b0;
            line_px_q    <= 1'b0;
            base_q       <= '0;
            addr_q       <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            line_err_q   <= 1'b0;
        end else begin
            row_q        <= row_d;
            col_q        <= col_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            href_prev_q  <= href_prev_d;
            line_px_q    <= line_px_d;
            base_q       <= base_d;
            addr_q       <= addr_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            frame_done_q <= frame_done_d;
            line_err_q   <= line_err_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign mem_we     = mem_we_q;
    assign frame_done = frame_done_q;
    assign line_err   = line_err_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 16x12 geometry so that every
// frame-level scenario fits in a short run.
`timescale 1ns/1ps
module tb_cam_capture;

    localparam int unsigned W  = 16;
    localparam int unsigned H  = 12;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          pclk;
    logic          vsync;
    logic          href;
    logic [7:0]    px;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_we;
    logic          frame_done;
    logic          line_err;

    int n_assert = 0;
    int n_fail   = 0;

    int            we_cnt = 0;
    int            fd_cnt = 0;
    logic [AW-1:0] wr_q[$];
    logic [7:0]    mem_m [0:(1<<AW)-1];

    cam_capture #(.IMG_W(W), .IMG_H(H), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .CAM_pclk    (pclk),
        .CAM_vsync   (vsync),
        .CAM_href    (href),
        .CAM_px_data (px),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .frame_done  (frame_done),
        .line_err    (line_err)
    );

    always #5 clk = ~clk;

    // Frame-buffer model and event counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            we_cnt++;
            wr_q.push_back(mem_addr);
            mem_m[mem_addr] = mem_data;
        end
        if (frame_done) fd_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic mon_clear();
        we_cnt = 0;
        fd_cnt = 0;
        wr_q.delete();
    endtask

    function automatic int seq_bad();
        int bad = 0;
        foreach (wr_q[i]) if (int'(wr_q[i]) != i) bad++;
        return bad;
    endfunction

    function automatic int max_wr();
        int m = 0;
        foreach (wr_q[i]) if (int'(wr_q[i]) > m) m = int'(wr_q[i]);
        return m;
    endfunction

    function automatic int count_range(input int lo, input int hi);
        int c = 0;
        foreach (wr_q[i]) if (int'(wr_q[i]) >= lo && int'(wr_q[i]) <= hi) c++;
        return c;
    endfunction

    function automatic logic [7:0] pat(input int r, input int k);
        if (r == 0) begin
            case (k)
                0: return 8'hF8;
                1: return 8'h00;
                2: return 8'h07;
                3: return 8'hE0;
                4: return 8'h00;
                5: return 8'h1F;
                6: return 8'hFF;
                7: return 8'hFF;
                default: ;
            endcase
        end
        return 8'(r * 7 + k * 3);
    endfunction

    // One pclk period = 4 clk: 2 low, 2 high; data changes with the falling edge.
    task automatic cam_cycle(input logic [7:0] d, input logic hr, input logic vs);
        @(negedge clk); pclk = 1'b0; px = d; href = hr; vsync = vs;
        @(negedge clk);
        @(negedge clk); pclk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_line(input int r, input int nb);
        for (int k = 0; k < nb; k++) cam_cycle(pat(r, k), 1'b1, 1'b0);
        repeat (2) cam_cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic vs_start();
        repeat (3) cam_cycle(8'h00, 1'b0, 1'b1);
        repeat (2) cam_cycle(8'h00, 1'b0, 1'b0);
    endtask

    task automatic vs_end();
        repeat (2) cam_cycle(8'h00, 1'b0, 1'b1);
    endtask

    task automatic frame(input int nl, input int nb, input int odd_r, input int odd_nb);
        vs_start();
        for (int r = 0; r < nl; r++) send_line(r, (r == odd_r) ? odd_nb : nb);
        vs_end();
    endtask

    initial begin
        logic [4:0] lat;
        logic       got;

        rst = 1'b1; enable = 1'b0; pclk = 1'b0; vsync = 1'b0; href = 1'b0; px = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_we",   32'(mem_we),     32'd0);
        check("rst_addr", 32'(mem_addr),   32'd0);
        check("rst_data", 32'(mem_data),   32'd0);
        check("rst_fd",   32'(frame_done), 32'd0);
        check("rst_lerr", 32'(line_err),   32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full frame with colour bars at the start of line 0.
        enable = 1'b1;
        mon_clear();
        frame(H, 2 * W, -1, 0);
        check("full_we_cnt",   we_cnt,           32'd192);
        check("full_last",     32'(wr_q[$]),     32'd191);
        check("full_seq",      seq_bad(),        32'd0);
        check("full_fd",       fd_cnt,           32'd1);
        check("full_lerr",     32'(line_err),    32'd0);
        check("full_addr_out", 32'(mem_addr),    32'd191);
        check("col_f800",      32'(mem_m[0]),    32'hE0);
        check("col_07e0",      32'(mem_m[1]),    32'h1C);
        check("col_001f",      32'(mem_m[2]),    32'h03);
        check("col_ffff",      32'(mem_m[3]),    32'hFF);
        check("col_row1",      32'(mem_m[16]),   32'h1D);

        // Write latency from the first clk edge that sees pclk high.
        mon_clear();
        vs_start();
        cam_cycle(8'h12, 1'b1, 1'b0);
        @(negedge clk); pclk = 1'b0; px = 8'h34; href = 1'b1; vsync = 1'b0;
        @(negedge clk);
        @(negedge clk); pclk = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            lat[n] = mem_we;
        end
        repeat (2) cam_cycle(8'h00, 1'b0, 1'b0);
        vs_end();
        check("lat_we_shape", 32'(lat),       32'b01000);
        check("lat_pixel",    32'(mem_m[0]),  32'h0A);
        check("lat_we_cnt",   we_cnt,         32'd1);
        check("lat_fd",       fd_cnt,         32'd1);

        // Odd byte count on line 5.
        mon_clear();
        frame(H, 2 * W, 5, 2 * W - 1);
        check("odd_we_cnt",   we_cnt,              32'd191);
        check("odd_line5",    count_range(80, 95), 32'd15);
        check("odd_line6_st", 32'(wr_q[95]),       32'd96);
        check("odd_lerr",     32'(line_err),       32'd1);
        check("odd_fd",       fd_cnt,              32'd1);
        check("odd_last",     32'(wr_q[$]),        32'd191);

        // Overlong lines and excess lines.
        mon_clear();
        frame(H + 2, 2 * W + 10, -1, 0);
        check("long_we_cnt", we_cnt,        32'd192);
        check("long_seq",    seq_bad(),     32'd0);
        check("long_max",    max_wr(),      32'd191);
        check("long_fd",     fd_cnt,        32'd1);
        check("long_lerr",   32'(line_err), 32'd0);

        // Enable dropped mid-frame: frame completes, next frame ignored.
        mon_clear();
        vs_start();
        for (int r = 0; r < 6; r++) send_line(r, 2 * W);
        enable = 1'b0;
        for (int r = 6; r < int'(H); r++) send_line(r, 2 * W);
        vs_end();
        check("endrop_we_cnt", we_cnt, 32'd192);
        check("endrop_fd",     fd_cnt, 32'd1);
        mon_clear();
        frame(H, 2 * W, -1, 0);
        check("dis_we_cnt", we_cnt, 32'd0);
        check("dis_fd",     fd_cnt, 32'd0);

        // Asynchronous reset in the middle of line 3.
        enable = 1'b1;
        mon_clear();
        vs_start();
        for (int r = 0; r < 3; r++) send_line(r, 2 * W);
        for (int k = 0; k < 6; k++) cam_cycle(pat(3, k), 1'b1, 1'b0);
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            if (mem_we) got = 1'b1;
        end
        check("arst_pre_we",   32'(got),      32'd1);
        check("arst_pre_addr", 32'(mem_addr), 32'd50);
        rst = 1'b1;
        #1;
        check("arst_we",   32'(mem_we),   32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_clear();
        for (int k = 6; k < int'(2 * W); k++) cam_cycle(pat(3, k), 1'b1, 1'b0);
        repeat (2) cam_cycle(8'h00, 1'b0, 1'b0);
        send_line(4, 2 * W);
        check("arst_idle_we", we_cnt, 32'd0);
        vs_start();
        send_line(0, 2 * W);
        vs_end();
        check("arst_resume_cnt",   we_cnt,        32'd16);
        check("arst_resume_first", 32'(wr_q[0]),  32'd0);
        check("arst_resume_fd",    fd_cnt,        32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
